mem_arbiter: RTL and testbench

- Round-robin arbiter that lets N_PORTS seq_core data ports share one single-ported sram.
- Sits between the cores and the sram in the multi-core top.
- Each cycle it grants at most one requester and drives the sram with that port's command. Every other requester is stalled until it is granted.
- Read data is routed back to the granted port with a per-port valid strobe. A saturating counter records contention.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared defaults and helpers for the memory arbiter and the round-robin
//   grant logic.
//   Contents:
//     *_DEF      default widths and port count
//     mem_op_e   operation issued to the sram for the granted port
//     rr_index   port visited k steps after the pointer, with wrap-around
`timescale 1ns/1ps
package mem_arbiter_pkg;

  localparam int D_SIZE_DEF  = 32;
  localparam int A_SIZE_DEF  = 10;
  localparam int N_PORTS_DEF = 4;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_e;

  function automatic int rr_index(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin grant. The search starts at ptr and
//   proceeds upward with wrap-around; the first requesting port wins.
//   Ports:
//     req        in   N_PORTS  request vector
//     ptr        in   IDX_W    highest-priority port this cycle
//     grant      out  N_PORTS  one-hot grant (all zero when nothing requests)
//     grant_idx  out  IDX_W    encoded grant index (0 when nothing requests)
`timescale 1ns/1ps
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = rr_index(int'(ptr), k, N_PORTS);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter letting N_PORTS cores share one single-ported sram.
//   At most one requester is granted per cycle; the rest see stall until
//   granted. Read data returns one cycle after the grant with a one-hot
//   per-port valid. A saturating counter records cycles with any stall.
//   Ports:
//     clk, rst_n                   clock, synchronous active-low reset
//     req_read/req_write           per-port request strobes
//     req_address/req_data_out     per-port address / write data, packed
//     stall                        per-port "not accepted this cycle"
//     rdata, rdata_valid           read return, broadcast data + one-hot owner
//     mem_read/mem_write           sram strobes
//     mem_address/mem_data_out     sram address / write data
//     mem_data_in                  sram read data (one cycle after mem_read)
//     contention_cnt               saturating count of contended cycles
`timescale 1ns/1ps
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int D_SIZE  = D_SIZE_DEF,
  parameter int A_SIZE  = A_SIZE_DEF,
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_PORTS-1:0]      req_read,
  input  logic [N_PORTS-1:0]      req_write,
  input  logic [N_PORTS*A_SIZE-1:0] req_address,
  input  logic [N_PORTS*D_SIZE-1:0] req_data_out,
  output logic [N_PORTS-1:0]      stall,
  output logic [D_SIZE-1:0]       rdata,
  output logic [N_PORTS-1:0]      rdata_valid,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [A_SIZE-1:0]       mem_address,
  output logic [D_SIZE-1:0]       mem_data_out,
  input  logic [D_SIZE-1:0]       mem_data_in,
  output logic [CNT_W-1:0]        contention_cnt
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;
  mem_op_e            op;

  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [N_PORTS-1:0] rdata_valid_reg;
  logic [D_SIZE-1:0]  rdata_hold_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [A_SIZE-1:0]  addr_arr [N_PORTS];
  logic [D_SIZE-1:0]  data_arr [N_PORTS];

  // Unpack the flat per-port buses so the mux can index by grant_idx.
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi] = req_address[gi*A_SIZE +: A_SIZE];
      assign data_arr[gi] = req_data_out[gi*D_SIZE +: D_SIZE];
    end
  endgenerate

  assign req = req_read | req_write;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Reset suppresses the grant so the sram sees no command while rst_n is low.
  assign any_grant = rst_n & (|grant);

  // Write wins when a port raises both strobes; the read is simply not issued.
  always_comb begin
    op           = OP_NONE;
    mem_address  = '0;
    mem_data_out = '0;
    if (any_grant) begin
      op           = req_write[grant_idx] ? OP_WRITE : OP_READ;
      mem_address  = addr_arr[grant_idx];
      mem_data_out = data_arr[grant_idx];
    end
  end

  assign mem_read  = (op == OP_READ);
  assign mem_write = (op == OP_WRITE);

  always_comb begin
    stall = req & ~grant;
    if (!rst_n) begin
      stall = '1;
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (any_grant) begin
      ptr_next = (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg         <= '0;
      rdata_valid_reg <= '0;
      rdata_hold_reg  <= '0;
      cnt_reg         <= '0;
    end else begin
      ptr_reg         <= ptr_next;
      rdata_valid_reg <= mem_read ? grant : '0;
      // Capture the returned word so rdata keeps it once the valid drops.
      if (|rdata_valid_reg) begin
        rdata_hold_reg <= mem_data_in;
      end
      if ((|stall) && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // The sram presents read data in the cycle after mem_read, so the return
  // cycle passes it straight through; otherwise the last value is held.
  assign rdata          = (|rdata_valid_reg) ? mem_data_in : rdata_hold_reg;
  assign rdata_valid    = rdata_valid_reg;
  assign contention_cnt = cnt_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int NP = 4;
  localparam int CW = 4;
  localparam logic [NP-1:0][9:0] A_STD = {10'h013, 10'h012, 10'h011, 10'h010};
  localparam logic [NP-1:0][9:0] A_RD  = {10'h043, 10'h005, 10'h021, 10'h040};

  typedef struct {
    string               tag;
    logic [NP-1:0]       rd;
    logic [NP-1:0]       wr;
    logic [NP-1:0][9:0]  addr;
    logic [NP-1:0][31:0] wdata;
    logic [NP-1:0]       exp_stall;
    int                  exp_gnt;
    logic                exp_mrd;
    logic                exp_mwr;
    logic [9:0]          exp_addr;
    logic [31:0]         exp_wd;
  } vec_t;

  typedef struct {
    int            due;
    logic [NP-1:0] vld;
    logic [31:0]   data;
  } sb_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NP-1:0]        req_read, req_write;
  logic [NP*10-1:0]     req_address;
  logic [NP*32-1:0]     req_data_out;
  logic [NP-1:0]        stall;
  logic [31:0]          rdata;
  logic [NP-1:0]        rdata_valid;
  logic                 mem_read, mem_write;
  logic [9:0]           mem_address;
  logic [31:0]          mem_data_out;
  logic [31:0]          mem_data_in;
  logic [CW-1:0]        contention_cnt;

  logic [31:0] sram [1024];
  logic [31:0] mem_q;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    model_cnt = 0;
  logic [31:0] exp_hold = '0;
  string cur_tag = "";
  sb_t   sb[$];
  vec_t  tbl[$];

  mem_arbiter #(
    .D_SIZE  (32),
    .A_SIZE  (10),
    .N_PORTS (NP),
    .CNT_W   (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_data_out   (req_data_out),
    .stall          (stall),
    .rdata          (rdata),
    .rdata_valid    (rdata_valid),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_mem(input logic [9:0] a);
    if (a == 10'h005) return 32'hDEADBEEF;
    return 32'h5A5A_0000 + 32'(a);
  endfunction

  // Single-ported sram with registered read.
  always @(posedge clk) begin
    if (mem_write) sram[mem_address] <= mem_data_out;
    if (mem_read)  mem_q <= sram[mem_address];
  end
  assign mem_data_in = mem_q;

  function automatic vec_t mk(input string tag, input logic [NP-1:0] rd,
                              input logic [NP-1:0] wr, input logic [NP-1:0][9:0] a,
                              input logic [NP-1:0] st, input int g);
    vec_t v;
    v.tag = tag; v.rd = rd; v.wr = wr; v.addr = a; v.exp_stall = st; v.exp_gnt = g;
    for (int p = 0; p < NP; p++) v.wdata[p] = 32'hC0DE_0000 + 32'(p << 12) + 32'(a[p]);
    v.exp_mrd = 1'b0; v.exp_mwr = 1'b0; v.exp_addr = '0; v.exp_wd = '0;
    if (g >= 0) begin
      v.exp_mrd  = rd[g] & ~wr[g];
      v.exp_mwr  = wr[g];
      v.exp_addr = a[g];
      v.exp_wd   = v.wdata[g];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: actual=%h required=%h", cur_tag, name, act, exp);
    end
  endtask

  task automatic check_return();
    sb_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rdata_valid", 32'(rdata_valid), 32'(e.vld));
      chk("rdata", rdata, e.data);
      exp_hold = e.data;
    end else begin
      chk("rdata_valid_idle", 32'(rdata_valid), 32'h0);
      chk("rdata_hold", rdata, exp_hold);
    end
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    @(posedge clk); #1;
    rst_n = 1'b1; req_read = v.rd; req_write = v.wr;
    req_address = v.addr; req_data_out = v.wdata;
    cyc++; cur_tag = v.tag;
    #3;
    chk("stall", 32'(stall), 32'(v.exp_stall));
    chk("mem_read", 32'(mem_read), 32'(v.exp_mrd));
    chk("mem_write", 32'(mem_write), 32'(v.exp_mwr));
    chk("mem_address", 32'(mem_address), 32'(v.exp_addr));
    chk("mem_data_out", mem_data_out, v.exp_wd);
    check_return();
    chk("contention_cnt", 32'(contention_cnt), 32'(model_cnt));
    $display("[TB] cyc %0d %s rd=%b wr=%b stall=%b mrd=%b mwr=%b addr=%h rv=%b rdata=%h cnt=%0d",
             cyc, v.tag, v.rd, v.wr, stall, mem_read, mem_write, mem_address,
             rdata_valid, rdata, contention_cnt);
    if (v.exp_mrd) begin
      e.due = cyc + 1;
      e.vld = NP'(1) << v.exp_gnt;
      e.data = exp_mem(v.exp_addr);
      sb.push_back(e);
    end
    if ((|v.exp_stall) && model_cnt < (1 << CW) - 1) model_cnt++;
  endtask

  task automatic do_reset(input int n, input logic [NP-1:0] rd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b0; req_read = rd; req_write = '0;
      req_address = A_RD; req_data_out = '1;
      cyc++; cur_tag = $sformatf("reset%0d", i);
      #3;
      chk("stall", 32'(stall), 32'hF);
      chk("mem_read", 32'(mem_read), 32'h0);
      chk("mem_write", 32'(mem_write), 32'h0);
      chk("mem_address", 32'(mem_address), 32'h0);
      chk("mem_data_out", mem_data_out, 32'h0);
      if (i > 0) begin
        chk("contention_cnt", 32'(contention_cnt), 32'h0);
        chk("rdata_valid", 32'(rdata_valid), 32'h0);
        chk("rdata", rdata, 32'h0);
      end
      $display("[TB] cyc %0d %s stall=%b mrd=%b mwr=%b cnt=%0d",
               cyc, cur_tag, stall, mem_read, mem_write, contention_cnt);
    end
    sb.delete();
    model_cnt = 0;
    exp_hold  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = exp_mem(10'(i));
    rst_n = 1'b0; req_read = '0; req_write = '0; req_address = '0; req_data_out = '0;

    // Round-robin, single requester, wrap/skip, read+write and back-to-back reads.
    tbl.push_back(mk("rr0",   4'b0000, 4'b1111, A_STD, 4'b1110, 0));
    tbl.push_back(mk("rr1",   4'b0000, 4'b1111, A_STD, 4'b1101, 1));
    tbl.push_back(mk("rr2",   4'b0000, 4'b1111, A_STD, 4'b1011, 2));
    tbl.push_back(mk("rr3",   4'b0000, 4'b1111, A_STD, 4'b0111, 3));
    tbl.push_back(mk("rr4",   4'b0000, 4'b1111, A_STD, 4'b1110, 0));
    tbl.push_back(mk("single",4'b0100, 4'b0000, A_RD,  4'b0000, 2));
    tbl.push_back(mk("ret2",  4'b0000, 4'b0000, A_RD,  4'b0000, -1));
    tbl.push_back(mk("wrap0", 4'b0101, 4'b0000, A_RD,  4'b0100, 0));
    tbl.push_back(mk("skip2", 4'b0101, 4'b0000, A_RD,  4'b0001, 2));
    tbl.push_back(mk("ret2b", 4'b0000, 4'b0000, A_RD,  4'b0000, -1));
    tbl.push_back(mk("rw1",   4'b0010, 4'b0010, A_STD, 4'b0000, 1));
    tbl.push_back(mk("rd0",   4'b0001, 4'b0000, A_RD,  4'b0000, 0));
    tbl.push_back(mk("rd3",   4'b1000, 4'b0000, A_RD,  4'b0000, 3));
    tbl.push_back(mk("ret3",  4'b0000, 4'b0000, A_RD,  4'b0000, -1));

    do_reset(2, 4'b1111);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Saturation: ports 0 and 1 alternate for 20 contended cycles.
    for (int i = 0; i < 20; i++) begin
      run_vec(mk($sformatf("sat%0d", i), 4'b0000, 4'b0011, A_STD,
                 (i % 2 == 0) ? 4'b0010 : 4'b0001, i % 2));
    end
    run_vec(mk("sat_hold", 4'b0000, 4'b0000, A_RD, 4'b0000, -1));
    chk("cnt_saturated", 32'(contention_cnt), 32'hF);

    // Read grant, then reset in the next cycle: the return is dropped.
    run_vec(mk("rd_pre_rst", 4'b0100, 4'b0000, A_RD, 4'b0000, 2));
    do_reset(1, 4'b1111);
    run_vec(mk("post_rst", 4'b0000, 4'b0000, A_RD, 4'b0000, -1));
    // Pointer restarted at 0, so port 1 wins over port 3.
    run_vec(mk("ptr_clr", 4'b1010, 4'b0000, A_RD, 4'b1000, 1));
    run_vec(mk("ret1", 4'b0000, 4'b0000, A_RD, 4'b0000, -1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
